// File: rtl/stream_to_axi_ax.sv
// Replays single-beat AXI-Stream Ax records as AXI4 AR/AW address requests.
// A small FIFO absorbs axready back-pressure; malformed beats are counted and dropped.
module stream_to_axi_ax #(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ADDR_WIDTH        = 64,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           BURST_LEN         = 8,
  parameter int                           LOCK_WIDTH        = 2,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = '0,
  parameter int                           FIFO_DEPTH        = 2,
  parameter logic [2:0]                   DEF_SIZE          = 3'b100,
  parameter logic [1:0]                   DEF_BURST         = 2'b01,
  parameter logic [3:0]                   DEF_CACHE         = 4'b0011,
  parameter logic [2:0]                   DEF_PROT          = 3'b000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [ID_WIDTH-1:0]   AXIM_axid,
  output logic [ADDR_WIDTH-1:0] AXIM_axaddr,
  output logic [BURST_LEN-1:0]  AXIM_axlen,
  output logic [2:0]            AXIM_axsize,
  output logic [1:0]            AXIM_axburst,
  output logic [3:0]            AXIM_axcache,
  output logic [2:0]            AXIM_axprot,
  output logic [LOCK_WIDTH-1:0] AXIM_axlock,
  output logic [3:0]            AXIM_axregion,
  output logic [3:0]            AXIM_axqos,
  output logic [USER_WIDTH-1:0] AXIM_axuser,
  output logic                  AXIM_axvalid,
  input  logic                  AXIM_axready,
  output logic                  drop,
  output logic [15:0]           err_count
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ID_WIDTH + BURST_LEN + ADDR_WIDTH;
  localparam int TYPE_LSB = DATA_WIDTH - STREAM_TYPE_WIDTH;
  localparam int ID_LSB   = TYPE_LSB - ID_WIDTH;
  localparam int LEN_LSB  = ID_LSB - BURST_LEN;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  if (DATA_WIDTH < STREAM_TYPE_WIDTH + ID_WIDTH + BURST_LEN + ADDR_WIDTH) begin : g_width_check
    $error("stream_to_axi_ax: DATA_WIDTH too small for the Ax record");
  end

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_drop;
  logic [15:0]        r_err_count;

  logic w_accept;
  logic w_good;
  logic w_push;
  logic w_pop;
  logic w_unused_pad;

  // Pad bits between len and addr carry no information
  if (LEN_LSB > ADDR_WIDTH) begin : g_pad
    assign w_unused_pad = ^s_tdata[LEN_LSB-1:ADDR_WIDTH];
  end else begin : g_no_pad
    assign w_unused_pad = 1'b0;
  end

  assign s_tready     = resetn && (r_count != FULL_CNT);
  assign AXIM_axvalid = (r_count != '0);

  assign w_accept = s_tvalid && s_tready;
  assign w_good   = (s_tdata[DATA_WIDTH-1:TYPE_LSB] == STREAM_TYPE) && s_tlast;
  assign w_push   = w_accept && w_good;
  assign w_pop    = AXIM_axvalid && AXIM_axready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_tdata[TYPE_LSB-1:ID_LSB], s_tdata[ID_LSB-1:LEN_LSB],
                          s_tdata[ADDR_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_drop      <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_drop <= w_accept && !w_good;
      if (w_accept && !w_good && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign {AXIM_axid, AXIM_axlen, AXIM_axaddr} = r_mem[r_rd_ptr];

  assign AXIM_axsize   = DEF_SIZE;
  assign AXIM_axburst  = DEF_BURST;
  assign AXIM_axcache  = DEF_CACHE;
  assign AXIM_axprot   = DEF_PROT;
  assign AXIM_axlock   = '0;
  assign AXIM_axregion = '0;
  assign AXIM_axqos    = '0;
  assign AXIM_axuser   = '0;

  assign drop      = r_drop;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_stream_to_axi_ax.sv
// Scoreboard bench for stream_to_axi_ax: the driver issues records, a negedge
// monitor models the FIFO as a queue and checks every request and status output.
module tb_stream_to_axi_ax;

  localparam int PAD_W = 128 - 3 - 32 - 8 - 64;

  typedef struct {
    logic [31:0] id;
    logic [7:0]  len;
    logic [63:0] addr;
  } rec_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [31:0]  AXIM_axid;
  logic [63:0]  AXIM_axaddr;
  logic [7:0]   AXIM_axlen;
  logic [2:0]   AXIM_axsize;
  logic [1:0]   AXIM_axburst;
  logic [3:0]   AXIM_axcache;
  logic [2:0]   AXIM_axprot;
  logic [1:0]   AXIM_axlock;
  logic [3:0]   AXIM_axregion;
  logic [3:0]   AXIM_axqos;
  logic [63:0]  AXIM_axuser;
  logic         AXIM_axvalid;
  logic         AXIM_axready;
  logic         drop;
  logic [15:0]  err_count;

  always #5 clk = ~clk;

  stream_to_axi_ax dut (
    .clk(clk), .resetn(resetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .AXIM_axid(AXIM_axid), .AXIM_axaddr(AXIM_axaddr), .AXIM_axlen(AXIM_axlen),
    .AXIM_axsize(AXIM_axsize), .AXIM_axburst(AXIM_axburst), .AXIM_axcache(AXIM_axcache),
    .AXIM_axprot(AXIM_axprot), .AXIM_axlock(AXIM_axlock), .AXIM_axregion(AXIM_axregion),
    .AXIM_axqos(AXIM_axqos), .AXIM_axuser(AXIM_axuser),
    .AXIM_axvalid(AXIM_axvalid), .AXIM_axready(AXIM_axready),
    .drop(drop), .err_count(err_count)
  );

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];
  logic [2:0] cur_type;
  logic       cur_last;
  rec_t       cur_rec;
  bit         mon_en    = 1'b0;
  bit         exp_drop  = 1'b0;
  bit         rand_rdy  = 1'b0;
  int         err_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rec_t rnd_rec();
    rec_t r;
    r.id   = $urandom;
    r.len  = 8'($urandom);
    r.addr = {$urandom, $urandom};
    return r;
  endfunction

  // Reference: a queue of at most two records, a drop flag and a saturating error count
  always @(negedge clk) begin
    if (mon_en) begin
      chk("axvalid", 64'(AXIM_axvalid), 64'(q.size() != 0));
      chk("s_tready", 64'(s_tready), 64'(q.size() < 2));
      chk("drop", 64'(drop), 64'(exp_drop));
      chk("err_count", 64'(err_count), 64'(err_model));
      if (AXIM_axvalid && AXIM_axready && q.size() != 0) begin
        chk("axid", 64'(AXIM_axid), 64'(q[0].id));
        chk("axlen", 64'(AXIM_axlen), 64'(q[0].len));
        chk("axaddr", AXIM_axaddr, q[0].addr);
        chk("axsize", 64'(AXIM_axsize), 64'd4);
        chk("axburst", 64'(AXIM_axburst), 64'd1);
        chk("axcache", 64'(AXIM_axcache), 64'd3);
        chk("axprot", 64'(AXIM_axprot), 64'd0);
        chk("axzero", 64'({AXIM_axlock, AXIM_axregion, AXIM_axqos}), 64'd0);
        chk("axuser", AXIM_axuser, 64'd0);
        void'(q.pop_front());
      end
      exp_drop = 1'b0;
      if (s_tvalid && s_tready) begin
        if (cur_type == 3'd0 && cur_last) q.push_back(cur_rec);
        else begin
          exp_drop = 1'b1;
          if (err_model < 65535) err_model++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      AXIM_axready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] typ, input logic last, input rec_t r);
    cur_type = typ;
    cur_last = last;
    cur_rec  = r;
    s_tdata  = {typ, r.id, r.len, PAD_W'($urandom), r.addr};
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout actual=stalled required=accepted");
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout actual=%0d required=0", q.size());
  endtask

  initial begin
    rec_t r;
    resetn       = 1'b0;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    AXIM_axready = 1'b0;
    cur_type     = '0;
    cur_last     = 1'b0;
    cur_rec      = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_axvalid", 64'(AXIM_axvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // single record
    AXIM_axready = 1'b1;
    r = '{id: 32'h5, len: 8'h3, addr: 64'h1000};
    send(3'd0, 1'b1, r);
    idle(3);

    // back-pressure: two fit, third waits for release
    AXIM_axready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(3'd0, 1'b1, rnd_rec());
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_tready", 64'(s_tready), 64'd0);
        chk("bp_axvalid", 64'(AXIM_axvalid), 64'd1);
        chk("bp_depth", 64'(q.size()), 64'd2);
        AXIM_axready = 1'b1;
      end
    join
    idle(2);
    drain();

    // streaming
    AXIM_axready = 1'b1;
    for (int i = 0; i < 8; i++) send(3'd0, 1'b1, rnd_rec());
    idle(3);

    // bad type, missing tlast, then a good record
    send(3'd5, 1'b1, rnd_rec());
    send(3'd0, 1'b0, rnd_rec());
    send(3'd0, 1'b1, rnd_rec());
    idle(3);
    chk("bad_err", 64'(err_count), 64'd2);

    // random traffic and back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 7) == 0) ? 3'd5 : 3'd0, 1'($urandom_range(0, 9) != 0), rnd_rec());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    AXIM_axready = 1'b1;
    drain();
    idle(2);

    // reset while two records queued
    AXIM_axready = 1'b0;
    send(3'd0, 1'b1, rnd_rec());
    send(3'd0, 1'b1, rnd_rec());
    chk("pre_rst_axvalid", 64'(AXIM_axvalid), 64'd1);
    chk("pre_rst_err_nz", 64'(err_count != 16'd0), 64'd1);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_axvalid", 64'(AXIM_axvalid), 64'd0);
    chk("mid_rst_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_err", 64'(err_count), 64'd0);
    chk("mid_rst_drop", 64'(drop), 64'd0);
    q.delete();
    err_model = 0;
    exp_drop  = 1'b0;
    resetn    = 1'b1;
    mon_en    = 1'b1;
    AXIM_axready = 1'b1;
    idle(2);

    // saturation
    for (int i = 0; i < 65537; i++) send(3'd5, 1'b1, rnd_rec());
    idle(2);
    chk("sat_err", 64'(err_count), 64'hFFFF);
    send(3'd0, 1'b1, rnd_rec());
    idle(3);
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
